// File: rtl/rs_age.sv
`default_nettype none
// ============================================================================
// Module      : rs_age
// Description : Reservation station with age-matrix issue ordering. Holds up
//               to DEPTH ops waiting on operands. Waiting sources capture
//               results from the common data bus. The oldest entry with both
//               operands ready is issued first.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_age #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  // dispatch
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [TAG_W-1:0]           disp_dtag,
  input  logic                       disp_rdy1,
  input  logic                       disp_rdy2,
  input  logic [DATA_W-1:0]          disp_val1,
  input  logic [DATA_W-1:0]          disp_val2,
  input  logic [TAG_W-1:0]           disp_tag1,
  input  logic [TAG_W-1:0]           disp_tag2,
  // result broadcast
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  // issue
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [DATA_W-1:0]          iss_src1,
  output logic [DATA_W-1:0]          iss_src2,
  output logic [OP_W-1:0]            iss_op,
  output logic [TAG_W-1:0]           iss_dtag,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Entry storage. age_q[i][j] = 1 means entry i was dispatched before entry j.
  logic [DEPTH-1:0]  bsy_q,  bsy_d;
  logic [DEPTH-1:0]  rdy1_q, rdy1_d;
  logic [DEPTH-1:0]  rdy2_q, rdy2_d;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [TAG_W-1:0]  dtag_q [DEPTH];
  logic [TAG_W-1:0]  dtag_d [DEPTH];
  logic [DATA_W-1:0] val1_q [DEPTH];
  logic [DATA_W-1:0] val1_d [DEPTH];
  logic [DATA_W-1:0] val2_q [DEPTH];
  logic [DATA_W-1:0] val2_d [DEPTH];
  logic [TAG_W-1:0]  tag1_q [DEPTH];
  logic [TAG_W-1:0]  tag1_d [DEPTH];
  logic [TAG_W-1:0]  tag2_q [DEPTH];
  logic [TAG_W-1:0]  tag2_d [DEPTH];
  logic [DEPTH-1:0]  age_q  [DEPTH];
  logic [DEPTH-1:0]  age_d  [DEPTH];

  logic [DEPTH-1:0]  elig;
  logic [DEPTH-1:0]  sel;
  logic [DEPTH-1:0]  free_oh;
  logic [DEPTH-1:0]  older;
  logic              free_found;
  logic              disp_fire;
  logic              iss_fire;
  logic              m1;
  logic              m2;
  logic [CNT_W-1:0]  cnt;

  // Occupancy, dispatch readiness and lowest free slot, all from registered state
  always_comb begin
    cnt        = '0;
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CNT_W'(bsy_q[i]);
      if (!bsy_q[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
    disp_ready = ~&bsy_q;
    count      = cnt;
  end

  // Oldest-eligible selection: an entry wins if no other eligible entry is older
  always_comb begin
    elig  = bsy_q & rdy1_q & rdy2_q;
    sel   = '0;
    older = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older[j] = age_q[j][i];
      end
      sel[i] = elig[i] & ~|(elig & older);
    end
  end

  // Issue payload, forced to zero when nothing is eligible
  always_comb begin
    iss_valid = |elig;
    iss_src1  = '0;
    iss_src2  = '0;
    iss_op    = '0;
    iss_dtag  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      iss_src1 = iss_src1 | (val1_q[i] & {DATA_W{sel[i]}});
      iss_src2 = iss_src2 | (val2_q[i] & {DATA_W{sel[i]}});
      iss_op   = iss_op   | (op_q[i]   & {OP_W{sel[i]}});
      iss_dtag = iss_dtag | (dtag_q[i] & {TAG_W{sel[i]}});
    end
  end

  assign disp_fire = disp_valid & disp_ready & ~flush;
  assign iss_fire  = iss_valid & iss_ready;
  assign m1        = cdb_valid & ~disp_rdy1 & (disp_tag1 == cdb_tag);
  assign m2        = cdb_valid & ~disp_rdy2 & (disp_tag2 == cdb_tag);

  // Next state: wakeup, issue clear, dispatch write, then flush overrides all
  always_comb begin
    bsy_d  = bsy_q;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    op_d   = op_q;
    dtag_d = dtag_q;
    val1_d = val1_q;
    val2_d = val2_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    age_d  = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && bsy_q[i] && !rdy1_q[i] && (tag1_q[i] == cdb_tag)) begin
        rdy1_d[i] = 1'b1;
        val1_d[i] = cdb_data;
      end
      if (cdb_valid && bsy_q[i] && !rdy2_q[i] && (tag2_q[i] == cdb_tag)) begin
        rdy2_d[i] = 1'b1;
        val2_d[i] = cdb_data;
      end
      if (iss_fire && sel[i]) begin
        bsy_d[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire && free_oh[i]) begin
        bsy_d[i]  = 1'b1;
        op_d[i]   = disp_op;
        dtag_d[i] = disp_dtag;
        rdy1_d[i] = disp_rdy1 | m1;
        rdy2_d[i] = disp_rdy2 | m2;
        val1_d[i] = m1 ? cdb_data : disp_val1;
        val2_d[i] = m2 ? cdb_data : disp_val2;
        tag1_d[i] = disp_tag1;
        tag2_d[i] = disp_tag2;
        // New entry is younger than everyone: clear its row, set its column
        age_d[i]  = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != i) begin
            age_d[j][i] = 1'b1;
          end
        end
      end
    end
    if (flush) begin
      bsy_d = '0;
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      bsy_q  <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        dtag_q[i] <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      bsy_q  <= bsy_d;
      rdy1_q <= rdy1_d;
      rdy2_q <= rdy2_d;
      op_q   <= op_d;
      dtag_q <= dtag_d;
      val1_q <= val1_d;
      val2_q <= val2_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      age_q  <= age_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_age.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_age
// Description : Directed self-checking bench for rs_age (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_age;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [TAG_W-1:0]  disp_dtag;
  logic              disp_rdy1, disp_rdy2;
  logic [DATA_W-1:0] disp_val1, disp_val2;
  logic [TAG_W-1:0]  disp_tag1, disp_tag2;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              iss_valid;
  logic              iss_ready;
  logic [DATA_W-1:0] iss_src1, iss_src2;
  logic [OP_W-1:0]   iss_op;
  logic [TAG_W-1:0]  iss_dtag;
  logic [$clog2(DEPTH):0] count;

  int passed = 0;
  int total  = 0;

  rs_age #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_dtag(disp_dtag),
    .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .disp_val1(disp_val1), .disp_val2(disp_val2),
    .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_op(iss_op), .iss_dtag(iss_dtag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // advance one clock; inputs change and outputs are sampled 1-2 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; disp_op = '0; disp_dtag = '0;
    disp_rdy1 = 0; disp_rdy2 = 0; disp_val1 = '0; disp_val2 = '0;
    disp_tag1 = '0; disp_tag2 = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; iss_ready = 0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dt,
                      input logic r1, input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] t1,
                      input logic r2, input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] t2);
    disp_valid = 1; disp_op = op; disp_dtag = dt;
    disp_rdy1 = r1; disp_val1 = v1; disp_tag1 = t1;
    disp_rdy2 = r2; disp_val2 = v2; disp_tag2 = t2;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    // reset state
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_iss_valid",  64'(iss_valid), 64'd0);
    chk("rst_iss_src1",   64'(iss_src1), 64'd0);
    chk("rst_iss_src2",   64'(iss_src2), 64'd0);
    chk("rst_iss_op",     64'(iss_op), 64'd0);
    chk("rst_iss_dtag",   64'(iss_dtag), 64'd0);
    chk("rst_count",      64'(count), 64'd0);

    // fill with four waiting entries (both sources on tags 1..4)
    iss_ready = 1;
    for (int i = 0; i < 4; i++) begin
      disp(OP_W'(i), TAG_W'(i), 0, '0, TAG_W'(i + 1), 0, '0, TAG_W'(i + 1));
      tick();
    end
    disp_valid = 0;
    #1;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_disp_ready", 64'(disp_ready), 64'd0);
    chk("fill_iss_valid", 64'(iss_valid), 64'd0);
    disp(12'hFF, 4'hF, 1, 32'h99, 0, 1, 32'h99, 0);
    tick();
    disp_valid = 0;
    #1;
    chk("fill_drop_count", 64'(count), 64'd4);
    chk("fill_drop_iss_valid", 64'(iss_valid), 64'd0);

    // wake entry 0; not issuable in the wakeup cycle
    iss_ready = 0;
    cdb(4'd1, 32'h11);
    #1;
    chk("wake0_latency", 64'(iss_valid), 64'd0);
    tick();
    // full, issue and dispatch together: dispatch dropped
    idle();
    iss_ready = 1;
    disp(12'hAA, 4'hA, 1, 32'h1, 0, 1, 32'h2, 0);
    #1;
    chk("full_iss_valid", 64'(iss_valid), 64'd1);
    chk("full_iss_op", 64'(iss_op), 64'd0);
    chk("full_iss_src1", 64'(iss_src1), 64'h11);
    chk("full_iss_src2", 64'(iss_src2), 64'h11);
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    tick();
    idle();
    #1;
    chk("full_after_count", 64'(count), 64'd3);
    chk("full_after_disp_ready", 64'(disp_ready), 64'd1);
    chk("full_after_iss_valid", 64'(iss_valid), 64'd0);
    flush = 1;
    tick();
    idle();
    #1;
    chk("flush1_count", 64'(count), 64'd0);

    // two-step CDB wakeup
    disp(12'h123, 4'd9, 0, '0, 4'd5, 0, '0, 4'd6);
    tick();
    idle();
    cdb(4'd5, 32'hA);
    #1;
    chk("wake_n_iss_valid", 64'(iss_valid), 64'd0);
    tick();
    cdb(4'd6, 32'hB);
    #1;
    chk("wake_n1_iss_valid", 64'(iss_valid), 64'd0);
    tick();
    idle();
    iss_ready = 1;
    #1;
    chk("wake_iss_valid", 64'(iss_valid), 64'd1);
    chk("wake_iss_src1", 64'(iss_src1), 64'hA);
    chk("wake_iss_src2", 64'(iss_src2), 64'hB);
    chk("wake_iss_op", 64'(iss_op), 64'h123);
    chk("wake_iss_dtag", 64'(iss_dtag), 64'd9);
    tick();
    #1;
    chk("wake_drained", 64'(count), 64'd0);

    // dispatch / CDB race
    idle();
    disp(12'h77, 4'd2, 0, 32'hDEAD, 4'd7, 1, 32'h66, 4'd0);
    cdb(4'd7, 32'h55);
    #1;
    chk("race_iss_valid_same", 64'(iss_valid), 64'd0);
    tick();
    idle();
    iss_ready = 1;
    #1;
    chk("race_iss_valid", 64'(iss_valid), 64'd1);
    chk("race_iss_src1", 64'(iss_src1), 64'h55);
    chk("race_iss_src2", 64'(iss_src2), 64'h66);
    tick();
    #1;
    chk("race_drained", 64'(count), 64'd0);

    // age order across slot reuse: A slot0, B slot1, issue A, C into slot0
    idle();
    disp(12'h00A, 4'd1, 0, '0, 4'd1, 1, 32'h0, 4'd0);
    tick();
    disp(12'h00B, 4'd2, 0, '0, 4'd2, 1, 32'h0, 4'd0);
    cdb(4'd1, 32'h100);
    tick();
    idle();
    iss_ready = 1;
    #1;
    chk("age_a_op", 64'(iss_op), 64'h00A);
    tick();
    idle();
    disp(12'h00C, 4'd3, 0, '0, 4'd2, 1, 32'h0, 4'd0);
    tick();
    idle();
    cdb(4'd2, 32'h200);
    #1;
    chk("age_count", 64'(count), 64'd2);
    tick();
    idle();
    iss_ready = 1;
    #1;
    chk("age_b_first", 64'(iss_op), 64'h00B);
    tick();
    #1;
    chk("age_c_second", 64'(iss_op), 64'h00C);
    chk("age_c_src1", 64'(iss_src1), 64'h200);
    tick();
    #1;
    chk("age_drained", 64'(count), 64'd0);

    // backpressure holds payload, then flush beats a dispatch
    idle();
    disp(12'h35, 4'd3, 1, 32'h31, 4'd0, 1, 32'h32, 4'd0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_iss_valid", 64'(iss_valid), 64'd1);
      chk("bp_iss_src1", 64'(iss_src1), 64'h31);
      chk("bp_iss_op", 64'(iss_op), 64'h35);
      tick();
    end
    flush = 1;
    disp(12'h44, 4'd4, 1, 32'h41, 4'd0, 1, 32'h42, 4'd0);
    tick();
    idle();
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_iss_valid", 64'(iss_valid), 64'd0);
    chk("flush_iss_src1", 64'(iss_src1), 64'd0);

    // reset mid-operation discards entries and pending wakeups
    disp(12'h51, 4'd5, 1, 32'h1, 4'd0, 1, 32'h2, 4'd0);
    tick();
    disp(12'h52, 4'd6, 0, '0, 4'd8, 1, 32'h2, 4'd0);
    tick();
    idle();
    rst = 1; iss_ready = 1; flush = 0;
    cdb(4'd8, 32'h88);
    disp(12'h53, 4'd7, 1, 32'h3, 4'd0, 1, 32'h4, 4'd0);
    tick();
    idle();
    rst = 0;
    #1;
    chk("rst_mid_count", 64'(count), 64'd0);
    chk("rst_mid_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_mid_disp_ready", 64'(disp_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
